reg_csr: RTL and testbench

Machine-mode CSR register file for the pipeline core: the responder end of the execute-stage CSR interface. Returns the current CSR value combinationally on the shared address, commits the execute stage's computed write value at the clock edge, and maintains the cycle/instret counters. Also holds trap state (entry/return), so mtvec, mepc and the interrupt-pending decision all come from one place.

---
 rtl/reg_csr.sv | 182 ++++++++++++++++++
 tb/tb_reg_csr.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_csr.sv
// Machine-mode CSR register file: combinational read mux, edge-committed writes,
// cycle/instret counters, trap entry/return state and the interrupt-pending decision.
module reg_csr #(
  parameter logic [63:0] HART_ID  = 64'd0,
  parameter logic [63:0] MISA_VAL = 64'h8000_0000_0000_1100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_we_i,
  input  logic [11:0] csr_addr_i,
  input  logic [63:0] csr_data_i,
  output logic [63:0] csr_data_o,
  output logic        csr_illegal_o,
  input  logic        instr_retire_i,
  input  logic        trap_i,
  input  logic [63:0] trap_pc_i,
  input  logic [63:0] trap_cause_i,
  input  logic [63:0] trap_val_i,
  input  logic        mret_i,
  input  logic        timer_irq_i,
  output logic [63:0] mtvec_o,
  output logic [63:0] mepc_o,
  output logic        irq_pending_o
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_CYCLE    = 12'hC00;
  localparam logic [11:0] A_INSTRET  = 12'hC02;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  localparam logic [63:0] MIE_MASK = 64'h0000_0000_0000_0888;

  logic        status_mie_r;
  logic        status_mpie_r;
  logic [63:0] mie_r;
  logic [63:0] mtvec_r;
  logic [63:0] mscratch_r;
  logic [63:0] mepc_r;
  logic [63:0] mcause_r;
  logic [63:0] mtval_r;
  logic        msip_r;
  logic        mtip_r;
  logic [63:0] mcycle_r;
  logic [63:0] minstret_r;

  logic [63:0] mstatus_s;
  logic [63:0] mip_s;
  logic [63:0] rdata_s;
  logic        known_s;
  logic        illegal_s;
  logic        wr_s;
  logic        trap_wr_s;

  assign mstatus_s = {51'd0, 2'b11, 3'd0, status_mpie_r, 3'd0, status_mie_r, 3'd0};
  assign mip_s     = {56'd0, mtip_r, 3'd0, msip_r, 3'd0};

  // Read mux; unknown addresses read zero and flag the access as illegal.
  always_comb begin
    rdata_s = 64'd0;
    known_s = 1'b1;
    case (csr_addr_i)
      A_MSTATUS:  rdata_s = mstatus_s;
      A_MISA:     rdata_s = MISA_VAL;
      A_MIE:      rdata_s = mie_r;
      A_MTVEC:    rdata_s = mtvec_r;
      A_MSCRATCH: rdata_s = mscratch_r;
      A_MEPC:     rdata_s = mepc_r;
      A_MCAUSE:   rdata_s = mcause_r;
      A_MTVAL:    rdata_s = mtval_r;
      A_MIP:      rdata_s = mip_s;
      A_MCYCLE:   rdata_s = mcycle_r;
      A_MINSTRET: rdata_s = minstret_r;
      A_CYCLE:    rdata_s = mcycle_r;
      A_INSTRET:  rdata_s = minstret_r;
      A_MHARTID:  rdata_s = HART_ID;
      default: begin
        rdata_s = 64'd0;
        known_s = 1'b0;
      end
    endcase
  end

  assign illegal_s = ~known_s | (csr_we_i & (csr_addr_i[11:10] == 2'b11));
  assign wr_s      = csr_we_i & ~illegal_s;
  // Trap entry and mret own mstatus/mepc/mcause/mtval for the cycle.
  assign trap_wr_s = wr_s & ~trap_i & ~mret_i;

  assign csr_data_o    = rdata_s;
  assign csr_illegal_o = illegal_s;
  assign mtvec_o       = mtvec_r;
  assign mepc_o        = mepc_r;
  assign irq_pending_o = status_mie_r & (|(mie_r & mip_s));

  // Free-running cycle and retire counters; a CSR write replaces that cycle's increment.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      mcycle_r   <= 64'd0;
      minstret_r <= 64'd0;
    end else begin
      if (wr_s && csr_addr_i == A_MCYCLE) begin
        mcycle_r <= csr_data_i;
      end else begin
        mcycle_r <= mcycle_r + 64'd1;
      end
      if (wr_s && csr_addr_i == A_MINSTRET) begin
        minstret_r <= csr_data_i;
      end else if (instr_retire_i) begin
        minstret_r <= minstret_r + 64'd1;
      end else begin
        minstret_r <= minstret_r;
      end
    end
  end

  // Plain software-writable CSRs with their WARL masks, plus the MTIP sampler.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      mie_r      <= 64'd0;
      mtvec_r    <= 64'd0;
      mscratch_r <= 64'd0;
      msip_r     <= 1'b0;
      mtip_r     <= 1'b0;
    end else begin
      mtip_r <= timer_irq_i;
      if (wr_s) begin
        case (csr_addr_i)
          A_MIE:      mie_r      <= csr_data_i & MIE_MASK;
          A_MTVEC:    mtvec_r    <= {csr_data_i[63:2], 2'b00};
          A_MSCRATCH: mscratch_r <= csr_data_i;
          A_MIP:      msip_r     <= csr_data_i[3];
          default:    mscratch_r <= mscratch_r;
        endcase
      end else begin
        mscratch_r <= mscratch_r;
      end
    end
  end

  // Trap state: trap entry beats mret, which beats a software write.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      status_mie_r  <= 1'b0;
      status_mpie_r <= 1'b0;
      mepc_r        <= 64'd0;
      mcause_r      <= 64'd0;
      mtval_r       <= 64'd0;
    end else if (trap_i) begin
      mepc_r        <= {trap_pc_i[63:2], 2'b00};
      mcause_r      <= trap_cause_i;
      mtval_r       <= trap_val_i;
      status_mpie_r <= status_mie_r;
      status_mie_r  <= 1'b0;
    end else if (mret_i) begin
      status_mie_r  <= status_mpie_r;
      status_mpie_r <= 1'b1;
    end else if (trap_wr_s) begin
      case (csr_addr_i)
        A_MSTATUS: begin
          status_mie_r  <= csr_data_i[3];
          status_mpie_r <= csr_data_i[7];
        end
        A_MEPC:   mepc_r   <= {csr_data_i[63:2], 2'b00};
        A_MCAUSE: mcause_r <= csr_data_i;
        A_MTVAL:  mtval_r  <= csr_data_i;
        default:  mepc_r   <= mepc_r;
      endcase
    end else begin
      mepc_r <= mepc_r;
    end
  end

endmodule

// File: tb/tb_reg_csr.sv
// Self-checking bench for reg_csr: expected reads are queued when the address is
// driven and popped when the combinational read data is sampled.
module tb_reg_csr;

  logic        clk;
  logic        rst_n;
  logic        csr_we_i;
  logic [11:0] csr_addr_i;
  logic [63:0] csr_data_i;
  logic [63:0] csr_data_o;
  logic        csr_illegal_o;
  logic        instr_retire_i;
  logic        trap_i;
  logic [63:0] trap_pc_i;
  logic [63:0] trap_cause_i;
  logic [63:0] trap_val_i;
  logic        mret_i;
  logic        timer_irq_i;
  logic [63:0] mtvec_o;
  logic [63:0] mepc_o;
  logic        irq_pending_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [63:0] data;
    logic        ill;
  } exp_t;
  exp_t sb[$];

  reg_csr #(.HART_ID(64'd0), .MISA_VAL(64'h8000_0000_0000_1100)) dut (
    .clk(clk), .rst_n(rst_n), .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i),
    .csr_data_i(csr_data_i), .csr_data_o(csr_data_o), .csr_illegal_o(csr_illegal_o),
    .instr_retire_i(instr_retire_i), .trap_i(trap_i), .trap_pc_i(trap_pc_i),
    .trap_cause_i(trap_cause_i), .trap_val_i(trap_val_i), .mret_i(mret_i),
    .timer_irq_i(timer_irq_i), .mtvec_o(mtvec_o), .mepc_o(mepc_o),
    .irq_pending_o(irq_pending_o)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Queue an expected read, let the mux settle, then pop and compare.
  task automatic rd(input string tag, input logic [11:0] addr, input logic [63:0] exp,
                    input logic exp_ill);
    exp_t e;
    csr_addr_i = addr;
    sb.push_back('{tag, exp, exp_ill});
    #1;
    e = sb.pop_front();
    check_eq(e.tag, csr_data_o, e.data);
    check_eq({e.tag, "_ill"}, {63'd0, csr_illegal_o}, {63'd0, e.ill});
  endtask

  task automatic wr(input logic [11:0] addr, input logic [63:0] data);
    csr_we_i   = 1'b1;
    csr_addr_i = addr;
    csr_data_i = data;
    step();
    csr_we_i   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; csr_we_i = 1'b0; csr_addr_i = 12'h000; csr_data_i = 64'd0;
    instr_retire_i = 1'b0; trap_i = 1'b0; trap_pc_i = 64'd0; trap_cause_i = 64'd0;
    trap_val_i = 64'd0; mret_i = 1'b0; timer_irq_i = 1'b0;
    @(negedge clk);
    step();
    step();
    rst_n = 1'b0;

    // Reset state
    rd("mcycle_first", 12'hB00, 64'd0, 1'b0);
    rd("mstatus_rst", 12'h300, 64'h1800, 1'b0);
    rd("misa", 12'h301, 64'h8000_0000_0000_1100, 1'b0);
    rd("mhartid", 12'hF14, 64'd0, 1'b0);
    rd("unimpl", 12'h7C0, 64'd0, 1'b1);
    check_eq("mtvec_o_rst", mtvec_o, 64'd0);
    check_eq("mepc_o_rst", mepc_o, 64'd0);
    check_eq("irq_rst", {63'd0, irq_pending_o}, 64'd0);
    step();
    rd("mcycle_second", 12'hB00, 64'd1, 1'b0);

    // Same-cycle read returns the old value; written value appears after the edge
    csr_we_i = 1'b1; csr_addr_i = 12'h340; csr_data_i = 64'hDEAD_BEEF_0000_1234;
    #1;
    check_eq("mscratch_nobypass", csr_data_o, 64'd0);
    step();
    csr_we_i = 1'b0;
    rd("mscratch", 12'h340, 64'hDEAD_BEEF_0000_1234, 1'b0);
    wr(12'h305, 64'h8000_0003);
    rd("mtvec", 12'h305, 64'h8000_0000, 1'b0);
    check_eq("mtvec_o", mtvec_o, 64'h8000_0000);

    // Counter wrap and write-wins-over-increment
    wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFE);
    rd("mcycle_wr", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    step();
    rd("mcycle_max", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    step();
    rd("mcycle_wrap", 12'hB00, 64'd0, 1'b0);
    wr(12'hB00, 64'd5);
    rd("mcycle_5", 12'hB00, 64'd5, 1'b0);
    step();
    rd("mcycle_6", 12'hB00, 64'd6, 1'b0);

    wr(12'hB02, 64'd10);
    instr_retire_i = 1'b1;
    step();
    step();
    instr_retire_i = 1'b0;
    rd("minstret_12", 12'hB02, 64'd12, 1'b0);
    step();
    rd("instret_hold", 12'hC02, 64'd12, 1'b0);
    instr_retire_i = 1'b1;
    wr(12'hB02, 64'd3);
    instr_retire_i = 1'b0;
    rd("minstret_wr_wins", 12'hB02, 64'd3, 1'b0);

    // Trap entry discards a concurrent mepc write; mret restores MIE
    wr(12'h300, 64'h8);
    rd("mstatus_mie", 12'h300, 64'h1808, 1'b0);
    trap_i = 1'b1; trap_pc_i = 64'h1002; trap_cause_i = 64'd11; trap_val_i = 64'h55;
    wr(12'h341, 64'h40);
    trap_i = 1'b0;
    rd("mepc_trap", 12'h341, 64'h1000, 1'b0);
    check_eq("mepc_o_trap", mepc_o, 64'h1000);
    rd("mcause_trap", 12'h342, 64'd11, 1'b0);
    rd("mtval_trap", 12'h343, 64'h55, 1'b0);
    rd("mstatus_trap", 12'h300, 64'h1880, 1'b0);
    mret_i = 1'b1;
    step();
    mret_i = 1'b0;
    rd("mstatus_mret", 12'h300, 64'h1888, 1'b0);
    mret_i = 1'b1;
    wr(12'h340, 64'h77);
    mret_i = 1'b0;
    rd("mscratch_during_mret", 12'h340, 64'h77, 1'b0);

    // Interrupt pending path
    wr(12'h304, 64'hFFFF_FFFF_FFFF_FFFF);
    rd("mie_mask", 12'h304, 64'h888, 1'b0);
    wr(12'h304, 64'h80);
    timer_irq_i = 1'b1;
    #1;
    check_eq("irq_lag", {63'd0, irq_pending_o}, 64'd0);
    step();
    check_eq("irq_set", {63'd0, irq_pending_o}, 64'd1);
    rd("mip_mtip", 12'h344, 64'h80, 1'b0);
    wr(12'h344, 64'hFFFF_FFFF_FFFF_FFFF);
    rd("mip_msip", 12'h344, 64'h88, 1'b0);
    wr(12'h344, 64'd0);
    rd("mip_clr", 12'h344, 64'h80, 1'b0);
    wr(12'h300, 64'd0);
    check_eq("irq_clr", {63'd0, irq_pending_o}, 64'd0);
    rd("mstatus_clr", 12'h300, 64'h1800, 1'b0);
    timer_irq_i = 1'b0;

    // Read-only writes are illegal and do not disturb state
    wr(12'hB00, 64'd100);
    csr_we_i = 1'b1; csr_addr_i = 12'hC00; csr_data_i = 64'd7;
    #1;
    check_eq("cycle_wr_ill", {63'd0, csr_illegal_o}, 64'd1);
    check_eq("cycle_wr_old", csr_data_o, 64'd100);
    step();
    csr_we_i = 1'b0;
    rd("cycle_counting", 12'hC00, 64'd101, 1'b0);
    wr(12'hF14, 64'h1234);
    rd("mhartid_ro", 12'hF14, 64'd0, 1'b0);

    // Reset mid-operation overrides writes and increments
    rst_n = 1'b1; instr_retire_i = 1'b1;
    wr(12'hB00, 64'd99);
    rst_n = 1'b0; instr_retire_i = 1'b0;
    rd("mcycle_rst", 12'hB00, 64'd0, 1'b0);
    rd("minstret_rst", 12'hB02, 64'd0, 1'b0);
    rd("mscratch_rst", 12'h340, 64'd0, 1'b0);
    rd("mstatus_rst2", 12'h300, 64'h1800, 1'b0);
    check_eq("mtvec_o_rst2", mtvec_o, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
